// File: rtl/mips_pc_pkg.sv
// mips_pc_pkg: shared state encoding and constants for the PC sequencer
package mips_pc_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: imem fetch handshake plus decode valid/ready and control inputs
//  master: sequencer side (drives imem_req/addr, instr_valid/instr/pc_out)
//  slave : imem + decode side (drives ack/rdata, ready and next-PC controls)
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic        jr;
  logic [31:0] jr_target;
  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc_out,
    input  imem_ack, imem_rdata, instr_ready, branch_taken, branch_offset, jump, jr, jr_target
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc_out,
    output imem_ack, imem_rdata, instr_ready, branch_taken, branch_offset, jump, jr, jr_target
  );
endinterface

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC select, priority jr > jump > branch > sequential
//  pc, instr_index, branch_taken/branch_offset, jump, jr/jr_target in; next_pc, misalign out
module next_pc_calc
  import mips_pc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_index,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        misalign
);
  logic [31:0] seq_pc;
  assign seq_pc = pc + PC_INC;
  assign next_pc = jr           ? {jr_target[31:2], 2'b00} :
                   jump         ? {seq_pc[31:28], instr_index, 2'b00} :
                   branch_taken ? seq_pc + (branch_offset << 2) :
                                  seq_pc;
  assign misalign = jr && (jr_target[1:0] != 2'b00);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, fetches from imem (req/ack) and hands words to decode (valid/ready)
//  clk, reset : clock, synchronous active-high reset
//  bus        : pc_sequencer_if.master (imem handshake, decode handshake, next-PC controls)
//  fetch_err  : sticky, a fetch waited FETCH_TIMEOUT cycles without ack
//  align_err  : sticky, a misaligned jr target was accepted
module pc_sequencer
  import mips_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = DEFAULT_RESET_PC,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pc_sequencer_if.master        bus,
  output logic                  fetch_err,
  output logic                  align_err
);
  localparam int CW = $clog2(FETCH_TIMEOUT + 1);
  state_t        state;
  logic [31:0]   pc;
  logic [CW-1:0] cnt;
  logic [31:0]   next_pc;
  logic          misalign;
  assign bus.imem_addr = pc;
  next_pc_calc u_next_pc (
    .pc           (pc),
    .instr_index  (bus.instr[25:0]),
    .branch_taken (bus.branch_taken),
    .branch_offset(bus.branch_offset),
    .jump         (bus.jump),
    .jr           (bus.jr),
    .jr_target    (bus.jr_target),
    .next_pc      (next_pc),
    .misalign     (misalign)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      bus.imem_req    <= 1'b0;
      bus.instr_valid <= 1'b0;
      bus.instr       <= '0;
      bus.pc_out      <= '0;
      fetch_err       <= 1'b0;
      align_err       <= 1'b0;
      cnt             <= '0;
    end else begin
      case (state)
        IDLE: begin
          state        <= FETCH;
          bus.imem_req <= 1'b1;
        end
        FETCH: begin
          if (bus.imem_ack) begin
            state           <= HOLD;
            bus.imem_req    <= 1'b0;
            bus.instr_valid <= 1'b1;
            bus.instr       <= bus.imem_rdata;
            bus.pc_out      <= pc;
            cnt             <= '0;
          end else begin
            // counter saturates at the limit; the flag latches on the cycle it gets there
            if (cnt != CW'(FETCH_TIMEOUT)) cnt <= cnt + 1'b1;
            if (cnt == CW'(FETCH_TIMEOUT - 1)) fetch_err <= 1'b1;
          end
        end
        HOLD: begin
          // instr_valid is always high here, so ready alone means accept
          if (bus.instr_ready) begin
            state           <= FETCH;
            pc              <= next_pc;
            align_err       <= align_err | misalign;
            bus.instr_valid <= 1'b0;
            bus.imem_req    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
